// File: rtl/cpu_stage_pkg.sv
// Shared stage encoding for the stage sequencer and the ALU controller.
package cpu_stage_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_FETCH      = 3'd0,
    ST_MEM_READ   = 3'd1,
    ST_REG_UPDATE = 3'd2,
    ST_MEM_WRITE  = 3'd3,
    ST_PC_UPDATE  = 3'd4,
    ST_HALTED     = 3'd5
  } stage_e;

  function automatic logic is_mem_wait(input stage_e st);
    return (st == ST_FETCH) || (st == ST_MEM_READ) || (st == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/memory handshake bundle of the stage sequencer.
// mem_fault exists only when STAGE_SEQ_TIMEOUT_EN is defined.
interface stage_sequencer_if;
  import cpu_stage_pkg::*;

  logic               need_mem_read;
  logic               need_mem_write;
  logic               mem_ack;
  logic               halt_req;
  logic [STAGE_W-1:0] stage;
  logic               mem_rd_req;
  logic               mem_wr_req;
  logic               instr_we;
  logic               reg_we;
  logic               pc_we;
  logic               halted;
  logic [31:0]        retired;

`ifdef STAGE_SEQ_TIMEOUT_EN
  logic               mem_fault;

  modport master (
    input  need_mem_read, need_mem_write, mem_ack, halt_req,
    output stage, mem_rd_req, mem_wr_req, instr_we, reg_we, pc_we,
    output halted, retired, mem_fault
  );

  modport slave (
    output need_mem_read, need_mem_write, mem_ack, halt_req,
    input  stage, mem_rd_req, mem_wr_req, instr_we, reg_we, pc_we,
    input  halted, retired, mem_fault
  );
`else
  modport master (
    input  need_mem_read, need_mem_write, mem_ack, halt_req,
    output stage, mem_rd_req, mem_wr_req, instr_we, reg_we, pc_we,
    output halted, retired
  );

  modport slave (
    output need_mem_read, need_mem_write, mem_ack, halt_req,
    input  stage, mem_rd_req, mem_wr_req, instr_we, reg_we, pc_we,
    input  halted, retired
  );
`endif

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive un-acknowledged memory wait cycles; expired flags the
// last allowed cycle so the sequencer leaves the wait state on that edge.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign expired = waiting && !ack && (r_count == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!waiting || ack || expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer (fetch / mem read / reg update /
// mem write / pc update / halted). Optional timeout: STAGE_SEQ_TIMEOUT_EN.
module stage_sequencer
  import cpu_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  stage_sequencer_if.master bus
);

  stage_e      r_state;
  stage_e      w_state_next;
  logic        r_need_wr;
  logic        w_need_wr_next;
  logic [31:0] r_retired;
  logic        w_waiting;
  logic        w_expired;
  logic        w_rd_req;
  logic        w_wr_req;
  logic        w_instr_we;
  logic        w_reg_we;
  logic        w_pc_we;

  assign w_waiting = is_mem_wait(r_state);

`ifdef STAGE_SEQ_TIMEOUT_EN
  logic r_mem_fault;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .waiting(w_waiting),
    .ack    (bus.mem_ack),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_fault <= 1'b0;
    end else if (w_expired) begin
      r_mem_fault <= 1'b1;
    end
  end

  assign bus.mem_fault = r_mem_fault;
`else
  logic w_unused_timeout;

  assign w_expired        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0) && w_waiting;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_need_wr <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_next;
      r_need_wr <= w_need_wr_next;
      if (r_state == ST_PC_UPDATE) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  // An ack that coincides with the last allowed cycle still wins over expiry.
  always_comb begin
    w_state_next   = r_state;
    w_need_wr_next = r_need_wr;
    w_rd_req       = 1'b0;
    w_wr_req       = 1'b0;
    w_instr_we     = 1'b0;
    w_reg_we       = 1'b0;
    w_pc_we        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_rd_req = 1'b1;
        if (bus.mem_ack) begin
          w_instr_we     = 1'b1;
          w_need_wr_next = bus.need_mem_write;
          w_state_next   = bus.need_mem_read ? ST_MEM_READ : ST_REG_UPDATE;
        end else if (w_expired) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_MEM_READ: begin
        w_rd_req = 1'b1;
        if (bus.mem_ack) begin
          w_state_next = ST_REG_UPDATE;
        end else if (w_expired) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_REG_UPDATE: begin
        w_reg_we     = 1'b1;
        w_state_next = r_need_wr ? ST_MEM_WRITE : ST_PC_UPDATE;
      end
      ST_MEM_WRITE: begin
        w_wr_req = 1'b1;
        if (bus.mem_ack) begin
          w_state_next = ST_PC_UPDATE;
        end else if (w_expired) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_PC_UPDATE: begin
        w_pc_we      = 1'b1;
        w_state_next = bus.halt_req ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  // Gate with rst_n so requests and strobes drop the instant reset asserts.
  assign bus.stage      = r_state;
  assign bus.mem_rd_req = w_rd_req && rst_n;
  assign bus.mem_wr_req = w_wr_req && rst_n;
  assign bus.instr_we   = w_instr_we && rst_n;
  assign bus.reg_we     = w_reg_we && rst_n;
  assign bus.pc_we      = w_pc_we && rst_n;
  assign bus.halted     = (r_state == ST_HALTED) && rst_n;
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer; timeout steps run when
// STAGE_SEQ_TIMEOUT_EN is defined.
module tb_stage_sequencer;
  import cpu_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  stage_sequencer_if bus ();

  stage_sequencer #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // {stage, rd_req, wr_req, instr_we, reg_we, pc_we, halted}
  function automatic logic [8:0] outs();
    return {bus.stage, bus.mem_rd_req, bus.mem_wr_req, bus.instr_we,
            bus.reg_we, bus.pc_we, bus.halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic ack, input logic nrd, input logic nwr, input logic halt);
    @(negedge clk);
    bus.mem_ack        = ack;
    bus.need_mem_read  = nrd;
    bus.need_mem_write = nwr;
    bus.halt_req       = halt;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [2:0] seq_stage [11];
  logic       seq_ack   [11];

  initial begin
    seq_stage = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    seq_ack   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.mem_ack        = 1'b0;
    bus.need_mem_read  = 1'b0;
    bus.need_mem_write = 1'b0;
    bus.halt_req       = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'({3'd0, 6'b000000}));
    chk("reset_retired", bus.retired, 32'd0);

    // minimal instruction: 0,2,4,0
    bus.mem_ack = 1'b1;
    release_reset();
    chk("min_fetch", 32'(outs()), 32'({3'd0, 6'b101000}));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("min_reg_ack_ignored", 32'(outs()), 32'({3'd2, 6'b000100}));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("min_pc", 32'(outs()), 32'({3'd4, 6'b000010}));
    chk("min_retired_pre", bus.retired, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("min_next_fetch", 32'(outs()), 32'({3'd0, 6'b100000}));
    chk("min_retired", bus.retired, 32'd1);

    // read + write with two wait cycles each; need_* only on fetch ack
    for (int i = 0; i < 11; i++) begin
      step(seq_ack[i], i == 2, i == 2, 1'b0);
      chk($sformatf("rw_stage_%0d", i), 32'(bus.stage), 32'(seq_stage[i]));
      chk($sformatf("rw_rd_%0d", i), 32'(bus.mem_rd_req),
          32'(seq_stage[i] == 3'd0 || seq_stage[i] == 3'd1));
      chk($sformatf("rw_wr_%0d", i), 32'(bus.mem_wr_req), 32'(seq_stage[i] == 3'd3));
      chk($sformatf("rw_overlap_%0d", i), 32'(bus.mem_rd_req & bus.mem_wr_req), 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rw_back_to_fetch", 32'(bus.stage), 32'd0);
    chk("rw_retired", bus.retired, 32'd2);

    // reset during MEM_WRITE
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_reg", 32'(bus.stage), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_memwrite_req", 32'(outs()), 32'({3'd3, 6'b010000}));
    rst_n = 1'b0;
    #1;
    chk("rst_drop_outs", 32'(outs()), 32'({3'd0, 6'b000000}));
    chk("rst_drop_retired", bus.retired, 32'd0);

    // halt_req in FETCH only: no halt
    bus.mem_ack  = 1'b1;
    bus.halt_req = 1'b1;
    release_reset();
    chk("halt_fetch_pulse", 32'(outs()), 32'({3'd0, 6'b101000}));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_pc_no_req", 32'(bus.stage), 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_not_taken", 32'(outs()), 32'({3'd0, 6'b100000}));
    chk("halt_retired1", bus.retired, 32'd1);

    // halt_req in PC_UPDATE: halt
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("halt_pc", 32'(bus.stage), 32'd4);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("halted_outs", 32'(outs()), 32'({3'd5, 6'b000001}));
    chk("halted_retired", bus.retired, 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("halted_sticky", 32'(outs()), 32'({3'd5, 6'b000001}));

    // retired wrap via forced preload
    rst_n = 1'b0;
    #1;
    chk("wrap_reset_outs", 32'(outs()), 32'({3'd0, 6'b000000}));
    bus.mem_ack = 1'b0;
    release_reset();
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    #1;
    chk("wrap_preload", bus.retired, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pc", 32'(bus.stage), 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_retired", bus.retired, 32'd0);

`ifdef STAGE_SEQ_TIMEOUT_EN
    // fetch never acked: four request cycles, then fault + halt
    rst_n = 1'b0;
    #1;
    chk("to_reset_fault", 32'(bus.mem_fault), 32'd0);
    bus.mem_ack = 1'b0;
    release_reset();
    chk("to_wait_0", 32'(outs()), 32'({3'd0, 6'b100000}));
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("to_wait_%0d", i), 32'(outs()), 32'({3'd0, 6'b100000}));
      chk($sformatf("to_fault_%0d", i), 32'(bus.mem_fault), 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_halted", 32'(outs()), 32'({3'd5, 6'b000001}));
    chk("to_fault", 32'(bus.mem_fault), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_fault_sticky", 32'(bus.mem_fault), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max cycles a memory request may wait for mem_ack.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port need_mem_read  input  1  decoded instruction requires a data read; sampled in REGISTER_UPDATE's predecessor (see REQ-013).
REQ-005 SHALL have port need_mem_write  input  1  decoded instruction requires a data write.
REQ-006 SHALL have port mem_ack  input  1  memory completes the outstanding request this cycle.
REQ-007 SHALL have port halt_req  input  1  stop after the current instruction retires.
REQ-008 SHALL have port stage  output  3  current stage code driven to the ALU controller.
REQ-009 SHALL have port mem_rd_req  output  1  read request (fetch or data), held until mem_ack.
REQ-010 SHALL have port mem_wr_req  output  1  write request, held until mem_ack.
REQ-011 SHALL have ports instr_we, reg_we, pc_we  output  1 each  one-cycle write strobes for instruction register, register file, PC.
REQ-012 SHALL have ports halted  output  1  and  retired  output  32  retired-instruction count.

Function
REQ-013 SHALL implement states FETCH=0, MEM_READ=1, REG_UPDATE=2, MEM_WRITE=3, PC_UPDATE=4, HALTED=5; stage output equals the state code.
REQ-014 FETCH: mem_rd_req=1; on mem_ack pulse instr_we that cycle, then go to MEM_READ if need_mem_read else REG_UPDATE (need_* sampled on the mem_ack cycle).
REQ-015 MEM_READ: mem_rd_req=1; on mem_ack go to REG_UPDATE.
REQ-016 REG_UPDATE: exactly one cycle, reg_we=1; next MEM_WRITE if need_mem_write (latched at fetch) else PC_UPDATE.
REQ-017 MEM_WRITE: mem_wr_req=1; on mem_ack go to PC_UPDATE.
REQ-018 PC_UPDATE: exactly one cycle, pc_we=1, retired increments by 1 (wraps 0xFFFFFFFF->0); next HALTED if halt_req else FETCH.
REQ-019 HALTED: all requests and strobes 0, halted=1; exit only via reset.
REQ-020 mem_rd_req and mem_wr_req SHALL never be 1 simultaneously; requests SHALL stay asserted and stable until mem_ack.
REQ-021 mem_ack outside a memory-wait state SHALL be ignored.
REQ-022 Minimum instruction latency SHALL be 3 cycles (FETCH with immediate ack, REG_UPDATE, PC_UPDATE); each memory stage adds cycles until ack.
REQ-023 halt_req asserted outside PC_UPDATE SHALL not abort the instruction; only its value in PC_UPDATE matters.

Reset
REQ-024 rst_n low SHALL immediately force state FETCH, all strobes and requests 0, halted=0, retired=0, latched need_* =0, timeout counter 0, mem_fault=0.
REQ-025 Reset mid-request SHALL drop the request asynchronously; first request after deassertion is a fetch on the next rising edge.

Configuration
REQ-026 With STAGE_SEQ_TIMEOUT_EN defined: a wait counter SHALL count cycles in FETCH/MEM_READ/MEM_WRITE without mem_ack; reaching TIMEOUT_CYCLES SHALL drop the request, set sticky output mem_fault (1 bit) and enter HALTED; counter clears on every ack and state change.
REQ-027 Without STAGE_SEQ_TIMEOUT_EN: no counter, no mem_fault port; memory waits are unbounded.

Structure
REQ-028 Stage codes (0-5) and state width SHALL live in shared package cpu_stage_pkg, also used by the ALU controller.
REQ-029 Timeout counter SHALL be sub-module mem_wait_timer (inputs clk, rst_n, waiting, ack; output expired), instantiated only under STAGE_SEQ_TIMEOUT_EN.

Verification
REQ-030 Reset release, mem_ack immediate, need_*=0 -> stage sequence 0,2,4,0; instr_we, reg_we, pc_we each pulse once; retired=1 after 3 cycles.
REQ-031 need_mem_read=1, need_mem_write=1, ack after 2 wait cycles each -> sequence 0,0,0,1,1,1,2,3,3,3,4; rd/wr never overlap.
REQ-032 halt_req=1 only in PC_UPDATE -> halted=1 next cycle, stage=5, no further requests; halt_req pulsed in FETCH only -> no halt.
REQ-033 rst_n low during MEM_WRITE -> mem_wr_req drops same cycle, retired=0, stage=0.
REQ-034 STAGE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack in FETCH -> after 4 cycles mem_fault=1, halted=1, mem_rd_req=0.
REQ-035 Preload retired=0xFFFFFFFF via forced state -> one retire wraps to 0.
